// File: rtl/pwr_seq.sv
// Power-down sequencer: drains the CPU bus, holds the core in reset, then drops board power.
// OFF is terminal; only a synchronous resetn leaves it.
module pwr_seq #(
    parameter int DRAIN_CYCLES  = 16,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int RST_HOLD      = 8,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       poweroff_rq,
    input  logic       mem_valid,
    output logic       cpu_resetn,
    output logic       pwr_en,
    output logic [1:0] seq_state,
    output logic       timed_out
);

    if (DRAIN_CYCLES < 1) begin : g_chk_dc
        $fatal(1, "pwr_seq: DRAIN_CYCLES must be >= 1");
    end
    if (RST_HOLD < 1) begin : g_chk_rh
        $fatal(1, "pwr_seq: RST_HOLD must be >= 1");
    end
    if (DRAIN_TIMEOUT <= DRAIN_CYCLES) begin : g_chk_to
        $fatal(1, "pwr_seq: DRAIN_TIMEOUT must exceed DRAIN_CYCLES");
    end
    if ((longint'(DRAIN_TIMEOUT) > (longint'(1) << CNT_W)) ||
        (longint'(RST_HOLD) > (longint'(1) << CNT_W))) begin : g_chk_w
        $fatal(1, "pwr_seq: counter values do not fit in CNT_W");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RESET = 2'd2,
        ST_OFF   = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timed_out_q, timed_out_d;
    logic             cpu_resetn_q, cpu_resetn_d;
    logic             pwr_en_q, pwr_en_d;

    logic idle_exit;
    logic tmo_exit;
    logic hold_done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign idle_exit = (state_q == ST_DRAIN) && !mem_valid && (idle_cnt_q == IDLE_LAST);
    assign tmo_exit  = (state_q == ST_DRAIN) && (tmo_cnt_q == TMO_LAST);
    assign hold_done = (state_q == ST_RESET) && (hold_cnt_q == HOLD_LAST);

    // NOTE: resetn is sampled on the clock edge (synchronous), so it lives inside the
    // clocked branch rather than in the sensitivity list; state uses <= only.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            idle_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            timed_out_q  <= 1'b0;
            cpu_resetn_q <= 1'b1;
            pwr_en_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            timed_out_q  <= timed_out_d;
            cpu_resetn_q <= cpu_resetn_d;
            pwr_en_q     <= pwr_en_d;
        end
    end

    // NOTE: every signal written in a combinational block gets a default first so no latch
    // is inferred on paths that do not assign it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (poweroff_rq) state_d = ST_DRAIN;
            ST_DRAIN: if (idle_exit || tmo_exit) state_d = ST_RESET;
            ST_RESET: if (hold_done) state_d = ST_OFF;
            ST_OFF:   state_d = ST_OFF;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                idle_cnt_d = '0;
                tmo_cnt_d  = '0;
                hold_cnt_d = '0;
            end
            ST_DRAIN: begin
                idle_cnt_d = mem_valid ? '0 : sat_inc(idle_cnt_q);
                tmo_cnt_d  = sat_inc(tmo_cnt_q);
                hold_cnt_d = '0;
            end
            ST_RESET: hold_cnt_d = sat_inc(hold_cnt_q);
            default:  ;
        endcase
    end

    // Outputs are decoded from the next state so they flop alongside it.
    always_comb begin
        cpu_resetn_d = (state_d == ST_IDLE) || (state_d == ST_DRAIN);
        pwr_en_d     = (state_d != ST_OFF);
        timed_out_d  = timed_out_q | (tmo_exit & ~idle_exit);
    end

    assign seq_state  = state_q;
    assign cpu_resetn = cpu_resetn_q;
    assign pwr_en     = pwr_en_q;
    assign timed_out  = timed_out_q;

endmodule
